pattern_gen_p: RTL and testbench
================================

Name: pattern_gen_p

Overview:
- Parametrised successor to the team's fixed 16-box pixel generator.
- Sits between the timing generator (pixel_cnt/line_cnt/h_sync/v_sync/video_on) and the DAC/HDMI output.
- Produces a runtime-selectable test pattern (vertical bars, horizontal bars, checkerboard, solid), using a writable palette and per-frame scrolling.
- Has a fixed 2-cycle pipeline, and the syncs are delayed to match it.

Parameters:
- CNT_W, 12, width of pixel_cnt/line_cnt
- COLOR_W, 8, bits per colour channel
- H_ACTIVE, 640, active pixels per line
- V_ACTIVE, 480, active lines per frame
- BAR_W, 40, tile width in pixels (>=1)
- BAR_H, 30, tile height in lines (>=1)
- PAL_DEPTH, 16, palette entries (power of 2, 2..256); PAL_AW = log2(PAL_DEPTH)

Ports:
- rfr_clk, in, 1, pixel clock
- reset, in, 1, synchronous active-high reset
- video_on, in, 1, active-video qualifier from the timing generator
- pixel_cnt, in, CNT_W, current pixel column
- line_cnt, in, CNT_W, current line
- h_sync, in, 1, horizontal sync (passed through delayed)
- v_sync, in, 1, vertical sync (passed through delayed)
- mode, in, 2, 0=VBARS 1=HBARS 2=CHECKER 3=SOLID
- scroll_en, in, 1, advance the pattern offset once per frame
- solid_idx, in, PAL_AW, palette index used in SOLID mode
- pal_we, in, 1, palette write strobe
- pal_addr, in, PAL_AW, palette write address
- pal_data, in, 3*COLOR_W, palette write data {R,G,B}
- p_red, out, COLOR_W, red
- p_green, out, COLOR_W, green
- p_blue, out, COLOR_W, blue
- h_sync_o, out, 1, h_sync delayed 2 cycles
- v_sync_o, out, 1, v_sync delayed 2 cycles

Behaviour:
- All state updates on posedge rfr_clk; reset has priority over every other input.
- Reset values:
  - outputs: p_* = 0, h_sync_o = 0, v_sync_o = 0
  - pipeline, tile counters and offset: 0
  - mode_q: 0
  - armed: 0
  - palette entry i = {c,c,c}, with c = i << (COLOR_W-PAL_AW) (grey ramp)
- Frame start (fs): pixel_cnt==0 && line_cnt==0.
- Armed flag:
  - set at the first fs after reset
  - while armed=0, p_* = 0 regardless of video_on, so a mid-frame reset never emits a partial pattern
- Frame-boundary updates at fs:
  - mode_q <= mode; mode changes mid-frame are ignored until the next fs
  - if scroll_en, offset <= (offset+1) mod PAL_DEPTH
- Column counter (no dividers):
  - sub_x and col reset to 0 when pixel_cnt==0
  - otherwise sub_x increments; when sub_x==BAR_W-1, sub_x <= 0 and col <= col+1 (PAL_AW bits, natural wrap)
- Row counter:
  - sub_y and row advance once per line when pixel_cnt==H_ACTIVE-1, using the same scheme with BAR_H
  - reset to 0 when line_cnt==0 at pixel_cnt==0
- Stage 1: registers idx, active_q and syncs.
  - active = video_on && pixel_cnt<H_ACTIVE && line_cnt<V_ACTIVE && armed
  - idx for VBARS = col+offset
  - idx for HBARS = row+offset
  - idx for CHECKER = col+row+offset
  - idx for SOLID = solid_idx (offset ignored)
  - all index sums truncate to PAL_AW bits
- Stage 2: registers palette[idx] into p_*, or 0 when active_q=0; syncs delayed again.
- Latency: pixel_cnt value N appears on p_* exactly 2 cycles later. h_sync_o/v_sync_o are aligned to it.
- Palette write:
  - single write port; palette[pal_addr] <= pal_data when pal_we
  - a same-cycle read of the same address returns the old data; the new data is visible from the next cycle
  - writes are accepted at any time, including during active video

Decomposition:
- Shared package pattern_pkg:
  - mode enum (MODE_VBARS, MODE_HBARS, MODE_CHECKER, MODE_SOLID)
  - BLACK constant
  - PIPE_LAT = 2
- One natural sub-module: tile_counter, parametrised by span. It supplies sub-count plus index with clear/advance inputs and is instantiated twice (x and y).
- The palette is an inferred register array inside the top level.

Test Plan:
- Reset, then a full 640x480 frame in VBARS, defaults, no writes -> first visible frame black (armed=0 until fs); next frame pixel 0..39 = 0x000000, pixel 40..79 = 0x101010, pixel 600..639 = 0xF0F0F0.
- CHECKER, scroll_en=0 -> pixel (40,30) uses index 2 = 0x202020; pixel (0,30) uses index 1 = 0x101010.
- VBARS, scroll_en=1 over 3 frames -> pixel 0 colour 0x101010, then 0x202020, then 0x303030; offset wraps after 16 frames back to 0x000000.
- Write pal_addr=5, pal_data=0xFF0000 in SOLID with solid_idx=5 -> 0xFF0000 from the cycle after write+2; same-cycle read returns the old 0x505050.
- Change mode at line 100 mid-frame -> pattern unchanged until the next fs; new mode from the first pixel of the next frame.
- Check latency and blanking -> h_sync_o/v_sync_o equal h_sync/v_sync delayed exactly 2 cycles; p_* = 0 whenever video_on=0 or pixel_cnt>=640; asserting reset at line 200 gives p_* = 0 the next cycle and until the following fs.

Source files
------------

// File: rtl/pattern_pkg.sv
// Shared types and constants for the pattern generator.
package pattern_pkg;

    typedef enum logic [1:0] {
        MODE_VBARS   = 2'd0,
        MODE_HBARS   = 2'd1,
        MODE_CHECKER = 2'd2,
        MODE_SOLID   = 2'd3
    } mode_e;

    localparam int BLACK    = 0;
    localparam int PIPE_LAT = 2;

endpackage

// File: rtl/pattern_gen_p_tile_counter.sv
// Divider-free tile position counter: sub-count within a tile plus tile index.
module tile_counter #(
    parameter int SPAN  = 40,
    parameter int IDX_W = 4,
    parameter int SUB_W = (SPAN > 1) ? $clog2(SPAN) : 1
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             clear_i,
    input  logic             advance_i,
    output logic [SUB_W-1:0] sub_o,
    output logic [IDX_W-1:0] idx_o,
    output logic [IDX_W-1:0] idxNext_o
);

    logic [SUB_W-1:0] sub_q, sub_d;
    logic [IDX_W-1:0] idx_q, idx_d;

    always_comb begin
        sub_d = sub_q;
        idx_d = idx_q;
        if (clear_i) begin
            sub_d = '0;
            idx_d = '0;
        end else if (advance_i) begin
            if (sub_q == SUB_W'(SPAN - 1)) begin
                sub_d = '0;
                idx_d = idx_q + IDX_W'(1);
            end else begin
                sub_d = sub_q + SUB_W'(1);
            end
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            sub_q <= '0;
            idx_q <= '0;
        end else begin
            sub_q <= sub_d;
            idx_q <= idx_d;
        end
    end

    assign sub_o     = sub_q;
    assign idx_o     = idx_q;
    assign idxNext_o = idx_d;

endmodule

// File: rtl/pattern_gen_p.sv
// Test-pattern generator between the video timing generator and the DAC/HDMI output.
// Stage 1 picks a palette index, stage 2 looks it up; syncs are delayed to match.
module pattern_gen_p #(
    parameter int CNT_W     = 12,
    parameter int COLOR_W   = 8,
    parameter int H_ACTIVE  = 640,
    parameter int V_ACTIVE  = 480,
    parameter int BAR_W     = 40,
    parameter int BAR_H     = 30,
    parameter int PAL_DEPTH = 16,
    localparam int PAL_AW   = $clog2(PAL_DEPTH)
) (
    input  logic                 rfr_clk,
    input  logic                 reset,
    input  logic                 video_on,
    input  logic [CNT_W-1:0]     pixel_cnt,
    input  logic [CNT_W-1:0]     line_cnt,
    input  logic                 h_sync,
    input  logic                 v_sync,
    input  logic [1:0]           mode,
    input  logic                 scroll_en,
    input  logic [PAL_AW-1:0]    solid_idx,
    input  logic                 pal_we,
    input  logic [PAL_AW-1:0]    pal_addr,
    input  logic [3*COLOR_W-1:0] pal_data,
    output logic [COLOR_W-1:0]   p_red,
    output logic [COLOR_W-1:0]   p_green,
    output logic [COLOR_W-1:0]   p_blue,
    output logic                 h_sync_o,
    output logic                 v_sync_o
);

    import pattern_pkg::*;

    localparam int RGB_W = 3 * COLOR_W;
    localparam int XSUB_W = (BAR_W > 1) ? $clog2(BAR_W) : 1;
    localparam int YSUB_W = (BAR_H > 1) ? $clog2(BAR_H) : 1;
    localparam logic [RGB_W-1:0] BLACK_RGB = RGB_W'(BLACK);

    function automatic logic [COLOR_W-1:0] greyLevel(input int entry);
        return COLOR_W'(entry) << (COLOR_W - PAL_AW);
    endfunction

    logic              frameStart;
    logic              lineEnd;
    mode_e             mode_q, mode_d;
    logic [PAL_AW-1:0] offset_q, offset_d;
    logic              armed_q, armed_d;

    logic [XSUB_W-1:0] xSub;
    logic [YSUB_W-1:0] ySub;
    logic [PAL_AW-1:0] xIdx, xIdxNext, yIdx, yIdxNext;
    logic [PAL_AW-1:0] col, row;
    logic              unusedTile;

    logic [PAL_AW-1:0] idx_q, idx_d;
    logic              active_q, active_d;
    logic [RGB_W-1:0]  rgb_q;
    logic [PIPE_LAT-1:0] hsPipe_q, vsPipe_q;
    logic [RGB_W-1:0]  palette_q [PAL_DEPTH];

    assign frameStart = (pixel_cnt == '0) && (line_cnt == '0);
    assign lineEnd    = (pixel_cnt == CNT_W'(H_ACTIVE - 1));

    tile_counter #(
        .SPAN  (BAR_W),
        .IDX_W (PAL_AW),
        .SUB_W (XSUB_W)
    ) u_xTile (
        .clock_i   (rfr_clk),
        .reset_i   (reset),
        .clear_i   (pixel_cnt == '0),
        .advance_i (1'b1),
        .sub_o     (xSub),
        .idx_o     (xIdx),
        .idxNext_o (xIdxNext)
    );

    tile_counter #(
        .SPAN  (BAR_H),
        .IDX_W (PAL_AW),
        .SUB_W (YSUB_W)
    ) u_yTile (
        .clock_i   (rfr_clk),
        .reset_i   (reset),
        .clear_i   (frameStart),
        .advance_i (lineEnd),
        .sub_o     (ySub),
        .idx_o     (yIdx),
        .idxNext_o (yIdxNext)
    );

    // Column advances with the pixel being sampled; the row only moves after a line ends.
    assign col = xIdxNext;
    assign row = frameStart ? '0 : yIdx;
    assign unusedTile = ^{xSub, ySub, xIdx, yIdxNext};

    always_comb begin
        mode_d   = mode_q;
        offset_d = offset_q;
        armed_d  = armed_q;
        if (frameStart) begin
            mode_d  = mode_e'(mode);
            armed_d = 1'b1;
            if (scroll_en) begin
                offset_d = offset_q + PAL_AW'(1);
            end
        end
    end

    always_comb begin
        idx_d = '0;
        unique case (mode_d)
            MODE_VBARS:   idx_d = col + offset_d;
            MODE_HBARS:   idx_d = row + offset_d;
            MODE_CHECKER: idx_d = col + row + offset_d;
            MODE_SOLID:   idx_d = solid_idx;
            default:      idx_d = '0;
        endcase
        active_d = video_on
                && (pixel_cnt < CNT_W'(H_ACTIVE))
                && (line_cnt < CNT_W'(V_ACTIVE))
                && armed_d;
    end

    always_ff @(posedge rfr_clk) begin
        if (reset) begin
            mode_q   <= MODE_VBARS;
            offset_q <= '0;
            armed_q  <= 1'b0;
            idx_q    <= '0;
            active_q <= 1'b0;
        end else begin
            mode_q   <= mode_d;
            offset_q <= offset_d;
            armed_q  <= armed_d;
            idx_q    <= idx_d;
            active_q <= active_d;
        end
    end

    // Palette lookup sees the pre-write contents when written in the same cycle.
    always_ff @(posedge rfr_clk) begin
        if (reset) begin
            for (int i = 0; i < PAL_DEPTH; i++) begin
                palette_q[i] <= {3{greyLevel(i)}};
            end
        end else if (pal_we) begin
            palette_q[pal_addr] <= pal_data;
        end
    end

    always_ff @(posedge rfr_clk) begin
        if (reset) begin
            rgb_q    <= BLACK_RGB;
            hsPipe_q <= '0;
            vsPipe_q <= '0;
        end else begin
            rgb_q    <= active_q ? palette_q[idx_q] : BLACK_RGB;
            hsPipe_q <= {hsPipe_q[PIPE_LAT-2:0], h_sync};
            vsPipe_q <= {vsPipe_q[PIPE_LAT-2:0], v_sync};
        end
    end

    assign p_red    = rgb_q[RGB_W-1 -: COLOR_W];
    assign p_green  = rgb_q[2*COLOR_W-1 -: COLOR_W];
    assign p_blue   = rgb_q[COLOR_W-1:0];
    assign h_sync_o = hsPipe_q[PIPE_LAT-1];
    assign v_sync_o = vsPipe_q[PIPE_LAT-1];

endmodule

// File: tb/tb_pattern_gen_p.sv
// Self-checking bench for pattern_gen_p on a shrunken raster, with a lock-step reference model.
module tb_pattern_gen_p;

    localparam int CNT_W = 12;
    localparam int HA    = 48;
    localparam int VA    = 24;
    localparam int BW    = 3;
    localparam int BH    = 2;
    localparam int PD    = 16;
    localparam int HT    = 54;
    localparam int VT    = 28;

    logic             clock = 1'b0;
    logic             reset;
    logic             video_on;
    logic [CNT_W-1:0] pixel_cnt, line_cnt;
    logic             h_sync, v_sync;
    logic [1:0]       mode;
    logic             scroll_en;
    logic [3:0]       solid_idx;
    logic             pal_we;
    logic [3:0]       pal_addr;
    logic [23:0]      pal_data;
    logic [7:0]       p_red, p_green, p_blue;
    logic             h_sync_o, v_sync_o;
    logic [23:0]      rgb;

    int testsRun    = 0;
    int testsFailed = 0;
    int hPos = 0;
    int vPos = 0;
    bit randVideo = 0;
    bit randSync  = 0;

    // Reference model state
    logic [23:0] mPal [PD];
    int          mMode, mOffset;
    bit          mArmed;
    int          s1Idx, s1Pix, s1Line;
    bit          s1Act, s1Hs, s1Vs, s1Vid;
    logic [23:0] expRgb;
    logic        expHs, expVs;
    int          expPix, expLine;
    bit          expVid;

    always #5 clock = ~clock;
    assign rgb = {p_red, p_green, p_blue};

    pattern_gen_p #(
        .CNT_W     (CNT_W),
        .COLOR_W   (8),
        .H_ACTIVE  (HA),
        .V_ACTIVE  (VA),
        .BAR_W     (BW),
        .BAR_H     (BH),
        .PAL_DEPTH (PD)
    ) dut (
        .rfr_clk   (clock),
        .reset     (reset),
        .video_on  (video_on),
        .pixel_cnt (pixel_cnt),
        .line_cnt  (line_cnt),
        .h_sync    (h_sync),
        .v_sync    (v_sync),
        .mode      (mode),
        .scroll_en (scroll_en),
        .solid_idx (solid_idx),
        .pal_we    (pal_we),
        .pal_addr  (pal_addr),
        .pal_data  (pal_data),
        .p_red     (p_red),
        .p_green   (p_green),
        .p_blue    (p_blue),
        .h_sync_o  (h_sync_o),
        .v_sync_o  (v_sync_o)
    );

    // Drive one raster position, clock it, advance the model, then move the raster on.
    task automatic applyStimulus();
        int col, row, idx;
        pixel_cnt = CNT_W'(hPos);
        line_cnt  = CNT_W'(vPos);
        video_on  = (hPos < HA) && (vPos < VA);
        if (randVideo) video_on = 1'($urandom_range(0, 1));
        h_sync = (hPos >= HA + 2) && (hPos < HA + 5);
        v_sync = (vPos >= VA + 1) && (vPos < VA + 3);
        if (randSync) begin
            h_sync = 1'($urandom_range(0, 1));
            v_sync = 1'($urandom_range(0, 1));
        end
        @(posedge clock);
        if (reset) begin
            expRgb = '0; expHs = 0; expVs = 0; expPix = -1; expLine = -1; expVid = 0;
        end else begin
            expRgb  = s1Act ? mPal[s1Idx] : 24'h000000;
            expHs   = s1Hs;
            expVs   = s1Vs;
            expPix  = s1Pix;
            expLine = s1Line;
            expVid  = s1Vid;
        end
        if (reset) begin
            for (int i = 0; i < PD; i++) mPal[i] = {3{8'(i * 16)}};
        end else if (pal_we) begin
            mPal[pal_addr] = pal_data;
        end
        if (reset) begin
            mArmed = 0; mMode = 0; mOffset = 0;
            s1Act = 0; s1Idx = 0; s1Hs = 0; s1Vs = 0; s1Pix = -1; s1Line = -1; s1Vid = 0;
        end else begin
            if (hPos == 0 && vPos == 0) begin
                mArmed = 1;
                mMode  = int'(mode);
                if (scroll_en) mOffset = (mOffset + 1) % PD;
            end
            col = (hPos / BW) % PD;
            row = (vPos / BH) % PD;
            case (mMode)
                0:       idx = (col + mOffset) % PD;
                1:       idx = (row + mOffset) % PD;
                2:       idx = (col + row + mOffset) % PD;
                default: idx = int'(solid_idx);
            endcase
            s1Idx  = idx;
            s1Act  = video_on && (hPos < HA) && (vPos < VA) && mArmed;
            s1Hs   = h_sync;
            s1Vs   = v_sync;
            s1Pix  = hPos;
            s1Line = vPos;
            s1Vid  = video_on;
        end
        #1;
        hPos++;
        if (hPos == HT) begin
            hPos = 0;
            vPos = (vPos + 1) % VT;
        end
    endtask

    task automatic test_reset();
        hPos = 7; vPos = 10;
        reset = 1;
        repeat (3) begin
            applyStimulus();
            testsRun++;
            if (rgb !== 24'h0 || h_sync_o !== 1'b0 || v_sync_o !== 1'b0) begin
                testsFailed++;
                $display("[TB] FAIL reset_values rgb=%h hs=%b vs=%b required rgb=000000 hs=0 vs=0", rgb, h_sync_o, v_sync_o);
            end
        end
        reset = 0;
        while (!(hPos == 0 && vPos == 0)) begin
            applyStimulus();
            testsRun++;
            if (rgb !== 24'h0 || h_sync_o !== expHs || v_sync_o !== expVs) begin
                testsFailed++;
                $display("[TB] FAIL unarmed_black pix=%0d line=%0d got rgb=%h hs=%b vs=%b required rgb=000000 hs=%b vs=%b",
                         expPix, expLine, rgb, h_sync_o, v_sync_o, expHs, expVs);
            end
        end
    endtask

    task automatic test_vbars();
        logic [23:0] want;
        mode = 2'd0;
        repeat (HT * VT) begin
            applyStimulus();
            testsRun++;
            if (rgb !== expRgb || h_sync_o !== expHs || v_sync_o !== expVs) begin
                testsFailed++;
                $display("[TB] FAIL vbars_model pix=%0d line=%0d got rgb=%h hs=%b vs=%b required rgb=%h hs=%b vs=%b",
                         expPix, expLine, rgb, h_sync_o, v_sync_o, expRgb, expHs, expVs);
            end
            if (expLine == 4 && (expPix == 0 || expPix == 2 || expPix == 3 || expPix == 5 || expPix == 45 || expPix == 47)) begin
                want = (expPix < 3) ? 24'h000000 : (expPix < 6) ? 24'h101010 : 24'hF0F0F0;
                testsRun++;
                if (rgb !== want) begin
                    testsFailed++;
                    $display("[TB] FAIL vbars_column pix=%0d got %h required %h", expPix, rgb, want);
                end
            end
        end
    endtask

    task automatic test_checker();
        logic [23:0] want;
        mode = 2'd2;
        scroll_en = 0;
        repeat (HT * VT) begin
            applyStimulus();
            testsRun++;
            if (rgb !== expRgb || h_sync_o !== expHs || v_sync_o !== expVs) begin
                testsFailed++;
                $display("[TB] FAIL checker_model pix=%0d line=%0d got rgb=%h required rgb=%h",
                         expPix, expLine, rgb, expRgb);
            end
            if ((expPix == 3 && expLine == 2) || (expPix == 0 && expLine == 2) || (expPix == 3 && expLine == 0)) begin
                want = (expPix == 3 && expLine == 2) ? 24'h202020 : 24'h101010;
                testsRun++;
                if (rgb !== want) begin
                    testsFailed++;
                    $display("[TB] FAIL checker_tile pix=%0d line=%0d got %h required %h", expPix, expLine, rgb, want);
                end
            end
        end
    endtask

    task automatic test_scroll();
        logic [23:0] want;
        mode = 2'd0;
        scroll_en = 1;
        for (int f = 1; f <= 16; f++) begin
            repeat (HT * VT) begin
                applyStimulus();
                testsRun++;
                if (rgb !== expRgb || h_sync_o !== expHs || v_sync_o !== expVs) begin
                    testsFailed++;
                    $display("[TB] FAIL scroll_model frame=%0d pix=%0d line=%0d got rgb=%h required rgb=%h",
                             f, expPix, expLine, rgb, expRgb);
                end
                if (expPix == 0 && expLine == 0) begin
                    want = 24'h101010 * 24'(f % 16);
                    testsRun++;
                    if (rgb !== want) begin
                        testsFailed++;
                        $display("[TB] FAIL scroll_pixel0 frame=%0d got %h required %h", f, rgb, want);
                    end
                end
            end
        end
        scroll_en = 0;
    endtask

    task automatic test_palette_write();
        logic [23:0] want;
        mode = 2'd3;
        solid_idx = 4'd5;
        repeat (HT * VT) begin
            if (hPos == 10 && vPos == 5) begin
                pal_we = 1; pal_addr = 4'd5; pal_data = 24'hFF0000;
            end
            applyStimulus();
            pal_we = 0;
            testsRun++;
            if (rgb !== expRgb || h_sync_o !== expHs || v_sync_o !== expVs) begin
                testsFailed++;
                $display("[TB] FAIL palette_model pix=%0d line=%0d got rgb=%h required rgb=%h",
                         expPix, expLine, rgb, expRgb);
            end
            if (expLine == 5 && (expPix == 9 || expPix == 10 || expPix == 11)) begin
                want = (expPix == 9) ? 24'h505050 : 24'hFF0000;
                testsRun++;
                if (rgb !== want) begin
                    testsFailed++;
                    $display("[TB] FAIL palette_write pix=%0d got %h required %h", expPix, rgb, want);
                end
            end
        end
    endtask

    task automatic test_mode_change();
        logic [23:0] want;
        mode = 2'd0;
        for (int f = 0; f < 2; f++) begin
            repeat (HT * VT) begin
                if (f == 0 && hPos == 0 && vPos == 10) mode = 2'd2;
                applyStimulus();
                testsRun++;
                if (rgb !== expRgb || h_sync_o !== expHs || v_sync_o !== expVs) begin
                    testsFailed++;
                    $display("[TB] FAIL modechg_model frame=%0d pix=%0d line=%0d got rgb=%h required rgb=%h",
                             f, expPix, expLine, rgb, expRgb);
                end
                if ((expPix == 3 && expLine == 12) || (expPix == 0 && expLine == 20)) begin
                    if (f == 0) want = (expPix == 3) ? 24'h101010 : 24'h000000;
                    else        want = (expPix == 3) ? 24'h707070 : 24'hA0A0A0;
                    testsRun++;
                    if (rgb !== want) begin
                        testsFailed++;
                        $display("[TB] FAIL mode_latch frame=%0d pix=%0d line=%0d got %h required %h",
                                 f, expPix, expLine, rgb, want);
                    end
                end
            end
        end
    endtask

    task automatic test_blanking_sync();
        bit afterReset = 0;
        randVideo = 1;
        randSync  = 1;
        repeat (HT * VT) begin
            if (hPos == 0 && vPos == 12) reset = 1;
            applyStimulus();
            if (reset) afterReset = 1;
            reset = 0;
            testsRun++;
            if (rgb !== expRgb || h_sync_o !== expHs || v_sync_o !== expVs) begin
                testsFailed++;
                $display("[TB] FAIL blank_model pix=%0d line=%0d got rgb=%h hs=%b vs=%b required rgb=%h hs=%b vs=%b",
                         expPix, expLine, rgb, h_sync_o, v_sync_o, expRgb, expHs, expVs);
            end
            if (afterReset || (expPix >= 0 && (!expVid || expPix >= HA))) begin
                testsRun++;
                if (rgb !== 24'h0) begin
                    testsFailed++;
                    $display("[TB] FAIL blanking pix=%0d line=%0d vid=%b postreset=%b got %h required 000000",
                             expPix, expLine, expVid, afterReset, rgb);
                end
            end
        end
        randVideo = 0;
        randSync  = 0;
    endtask

    task automatic test_random();
        for (int f = 0; f < 3; f++) begin
            mode      = 2'($urandom_range(0, 3));
            scroll_en = 1'($urandom_range(0, 1));
            solid_idx = 4'($urandom_range(0, 15));
            repeat (HT * VT) begin
                if (hPos == 0 && $urandom_range(0, 3) == 0) mode = 2'($urandom_range(0, 3));
                pal_we   = ($urandom_range(0, 7) == 0);
                pal_addr = 4'($urandom_range(0, 15));
                pal_data = 24'($urandom);
                applyStimulus();
                pal_we = 0;
                testsRun++;
                if (rgb !== expRgb || h_sync_o !== expHs || v_sync_o !== expVs) begin
                    testsFailed++;
                    $display("[TB] FAIL random_model frame=%0d pix=%0d line=%0d got rgb=%h required rgb=%h",
                             f, expPix, expLine, rgb, expRgb);
                end
            end
        end
        scroll_en = 0;
    endtask

    initial begin
        reset = 1; mode = 2'd0; scroll_en = 0; solid_idx = '0;
        pal_we = 0; pal_addr = '0; pal_data = '0;
        pixel_cnt = '0; line_cnt = '0; video_on = 0; h_sync = 0; v_sync = 0;
        test_reset();
        test_vbars();
        test_checker();
        test_scroll();
        test_palette_write();
        test_mode_change();
        test_blanking_sync();
        test_random();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
